// File: rtl/grant_dispatch_queue.sv
// Queues one-hot arbiter grants as requester indices and serves them in arrival
// order as fixed-length valid/ready bursts, pulsing done to each served requester.
module grant_dispatch_queue #(
    parameter int unsigned N      = 4,
    parameter int unsigned ID_W   = 2,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned BEAT_W = 4,
    parameter int unsigned LVL_W  = 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [N-1:0]          grant,
    input  logic [N*BEAT_W-1:0]   beats_cfg,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [ID_W-1:0]       out_id,
    output logic [BEAT_W-1:0]     out_beat,
    output logic                  out_last,
    output logic [N-1:0]          done,
    output logic [LVL_W-1:0]      fifo_level,
    output logic                  overflow,
    output logic                  onehot_err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [ID_W-1:0]      r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [LVL_W-1:0]     r_count;

    logic [ID_W-1:0]      r_id;
    logic [BEAT_W-1:0]    r_beat;
    logic [BEAT_W-1:0]    r_last_idx;
    logic                 r_valid;
    logic                 r_last;
    logic [N-1:0]         r_done;
    logic                 r_overflow;
    logic                 r_onehot_err;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_fire;
    logic                 w_at_last;
    logic                 w_pop;
    logic                 w_load;
    logic                 w_beat_inc;
    logic                 w_burst_done;
    logic                 w_push;
    logic                 w_drop;

    logic                 w_grant_onehot;
    logic                 w_grant_multi;
    logic [ID_W-1:0]      w_grant_idx;

    logic [ID_W-1:0]      w_head_id;
    logic [BEAT_W-1:0]    w_cfg;
    logic [ID_W-1:0]      w_id_nxt;
    logic [BEAT_W-1:0]    w_beat_nxt;
    logic [BEAT_W-1:0]    w_last_idx_nxt;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == LVL_W'(DEPTH));
    assign w_fire    = (r_state == S_RUN) && out_ready;
    assign w_at_last = (r_beat == r_last_idx);
    assign w_head_id = r_mem[r_rd_ptr];

    // Grant decode: one-hot pushes its index, multi-hot is a protocol error
    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (grant[i]) w_grant_idx = ID_W'(i);
        end
    end

    assign w_grant_onehot = (grant != '0) && ((grant & (grant - N'(1))) == '0);
    assign w_grant_multi  = (grant != '0) && !w_grant_onehot;
    assign w_push         = w_grant_onehot && (!w_full || w_pop);
    assign w_drop         = w_grant_onehot && w_full && !w_pop;

    always_comb begin
        w_cfg = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (w_head_id == ID_W'(i)) w_cfg = beats_cfg[i*BEAT_W +: BEAT_W];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and burst sequencing; a last-beat handshake reloads from the queue without a bubble
    always_comb begin
        w_state_nxt    = r_state;
        w_pop          = 1'b0;
        w_load         = 1'b0;
        w_beat_inc     = 1'b0;
        w_burst_done   = 1'b0;
        w_id_nxt       = r_id;
        w_beat_nxt     = r_beat;
        w_last_idx_nxt = r_last_idx;

        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_fire) begin
                    if (w_at_last) begin
                        w_burst_done = 1'b1;
                        if (!w_empty) begin
                            w_pop  = 1'b1;
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_beat_inc = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_load) begin
            w_id_nxt       = w_head_id;
            w_beat_nxt     = '0;
            w_last_idx_nxt = (w_cfg == '0) ? '0 : (w_cfg - BEAT_W'(1));
        end else if (w_beat_inc) begin
            w_beat_nxt = r_beat + BEAT_W'(1);
        end
    end

    // Queue storage needs no reset; occupancy is governed by the pointers
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_grant_idx;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + LVL_W'(w_push) - LVL_W'(w_pop);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_id         <= '0;
            r_beat       <= '0;
            r_last_idx   <= '0;
            r_valid      <= 1'b0;
            r_last       <= 1'b0;
            r_done       <= '0;
            r_overflow   <= 1'b0;
            r_onehot_err <= 1'b0;
        end else begin
            r_id         <= w_id_nxt;
            r_beat       <= w_beat_nxt;
            r_last_idx   <= w_last_idx_nxt;
            r_valid      <= (w_state_nxt == S_RUN);
            r_last       <= (w_state_nxt == S_RUN) && (w_beat_nxt == w_last_idx_nxt);
            r_done       <= w_burst_done ? (N'(1) << r_id) : '0;
            if (w_drop)        r_overflow   <= 1'b1;
            if (w_grant_multi) r_onehot_err <= 1'b1;
        end
    end

    assign out_valid  = r_valid;
    assign out_id     = r_id;
    assign out_beat   = r_beat;
    assign out_last   = r_last;
    assign done       = r_done;
    assign fifo_level = r_count;
    assign overflow   = r_overflow;
    assign onehot_err = r_onehot_err;

endmodule

// File: doc/grant_dispatch_queue.md
Name: grant_dispatch_queue

Overview:
- Sits directly downstream of the 4-requester fixed-order arbiter with pending. Consumes its one-hot grant vector.
- Queues each granted requester index in a small FIFO.
- Serves queued requesters in order: emits a burst of per-requester configurable length on a valid/ready service interface.
- Returns a one-cycle done pulse to the served requester and flags protocol errors (non-one-hot grant, queue overflow).

Parameters:
- N, 4, number of requesters (grant width).
- ID_W, 2, index width; must equal clog2(N).
- DEPTH, 4, FIFO entries (power of two).
- BEAT_W, 4, burst-length / beat-counter width.
- LVL_W, 3, fifo_level width; must equal clog2(DEPTH+1).

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous active-low reset.
- grant  input  N  one-hot grant from arbiter; sampled every rising edge.
- beats_cfg  input  N*BEAT_W  burst length per requester; field i = bits [i*BEAT_W +: BEAT_W].
- out_ready  input  1  downstream accepts the current beat.
- out_valid  output  1  service beat valid.
- out_id  output  ID_W  requester index being served.
- out_beat  output  BEAT_W  beat number within burst, starting at 0.
- out_last  output  1  current beat is the final beat of the burst.
- done  output  N  one-cycle pulse on bit out_id after the final beat is accepted.
- fifo_level  output  LVL_W  number of queued entries.
- overflow  output  1  sticky: a valid grant was dropped.
- onehot_err  output  1  sticky: a multi-hot grant was seen.

Behaviour:
- Reset (async, rstn=0): FIFO emptied and pointers cleared; FSM goes to IDLE. Effective immediately, including mid-burst.
  - out_valid, out_id, out_beat, out_last, done, fifo_level, overflow and onehot_err all read 0.
- Grant decode each edge:
  - grant==0: no action.
  - grant one-hot: push its encoded index.
  - grant with >1 bit set: no push; onehot_err<=1.
  - Sticky flags clear only on reset.
- Push/pop rules:
  - Push when full and no pop in the same cycle: entry dropped, overflow<=1.
  - Push when full with a simultaneous pop: push accepted, level unchanged.
  - Pop never occurs when empty.
  - fifo_level tracks the occupancy registered at each edge.
- FSM states: IDLE, RUN.
  - IDLE: if FIFO not empty at an edge, pop the head, latch id, latch len = beats_cfg[id] (0 treated as 1), clear the beat counter, go to RUN.
  - IDLE: out_valid=0.
  - RUN: out_valid=1, out_id=latched id, out_beat=counter, out_last=(counter==len-1).
  - RUN, handshake (out_valid & out_ready) on a non-last beat: counter+1.
  - RUN, handshake on the last beat: done[id]<=1 for exactly one cycle. Then, if the FIFO is non-empty, pop and load the next entry in the same edge (no bubble, out_valid stays 1); otherwise go to IDLE.
  - No handshake: all outputs hold (stable under backpressure).
- beats_cfg is sampled only at load. Changes mid-burst do not affect the active burst.
- Latency: a grant present at edge E0 is pushed at E0, popped/loaded at E1; out_valid=1 after E1.
- Ordering: strict FIFO order of grant arrival. A requester may appear multiple times in the queue.
- done is registered: it asserts in the cycle after the last-beat handshake edge and deasserts after one cycle.

Test Plan:
- Reset: hold rstn=0 with grant=4'b1111 and out_ready=1 → all outputs 0, fifo_level=0. Assert rstn=0 mid-burst → out_valid drops immediately, no done pulse.
- Single grant: grant=4'b0100 for one cycle, beats_cfg[2]=3, out_ready=1 → out_valid rises 2 edges later with out_id=2. Expected out_beat sequence 0,1,2; out_last on beat 2; done=4'b0100 for one cycle; FSM returns to IDLE.
- Back-to-back: grants 4'b0001, 4'b0010, 4'b1000 on consecutive cycles, all lengths 2, ready=1 → 6 consecutive valid cycles, ids 0,0,1,1,3,3 with no bubble. done pulses 0001, 0010, 1000 in that order.
- Backpressure: burst length 4, drop out_ready for 5 cycles at beat 1 → out_beat stays 1, out_valid stays 1, no done. Burst then completes 2,3 after ready returns.
- Overflow: out_ready=0, six single-cycle grants with ids 0,1,2,3,0,1 → fifo_level reaches 4, overflow=1 (loaded entry plus 4 queued; 6th dropped). With ready=1 afterwards → service order 0,1,2,3,0.
- Error/edge: grant=4'b0110 → onehot_err=1, fifo_level unchanged. beats_cfg[3]=0 with grant=4'b1000 → single beat, out_last=1 on beat 0, done=4'b1000.
